// File: rtl/sc_mul_seq.sv
// sc_mul_seq: sequential stochastic-computing multiplier, LANES stream bits per cycle
module sc_mul_seq #(
  parameter int LOG_LEN  = 5,
  parameter int LANES    = 4,
  parameter int IN_WIDTH = LOG_LEN + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] a_in,
  input  logic [IN_WIDTH-1:0] b_in,
  input  logic                bipolar,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LOG_LEN:0]    sc_result
);
  localparam int L = 1 << LOG_LEN;
  localparam int W = IN_WIDTH > LOG_LEN + 1 ? IN_WIDTH : LOG_LEN + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [LOG_LEN:0] a_q, b_q, acc, cnt;
  logic [LOG_LEN-1:0] idx;
  logic bip_q, last;
  logic [W-1:0] a_x, b_x;
  function automatic logic prod_bit(input logic [LOG_LEN-1:0] i, input logic [LOG_LEN:0] a,
                                    input logic [LOG_LEN:0] b, input logic bip);
    logic [LOG_LEN-1:0] r;
    logic sa, sb;
    for (int j = 0; j < LOG_LEN; j++) r[j] = i[LOG_LEN-1-j];
    sa = {1'b0, i} < a;
    sb = {1'b0, r} < b;
    return bip ? sa ~^ sb : sa & sb;
  endfunction
  assign a_x = W'(a_in);
  assign b_x = W'(b_in);
  assign last = idx == LOG_LEN'(L - LANES);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign sc_result = acc;
  always_comb begin
    cnt = '0;
    for (int k = 0; k < LANES; k++)
      cnt = cnt + (LOG_LEN+1)'(prod_bit(idx + LOG_LEN'(k), a_q, b_q, bip_q));
  end
  always_comb begin
    state_n = state == IDLE ? (in_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
              (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // operands saturate at L so the comparators never see an out-of-range value
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      bip_q <= 1'b0;
      acc <= '0;
      idx <= '0;
    end else if (state == IDLE && in_valid) begin
      a_q <= a_x > W'(L) ? (LOG_LEN+1)'(L) : a_x[LOG_LEN:0];
      b_q <= b_x > W'(L) ? (LOG_LEN+1)'(L) : b_x[LOG_LEN:0];
      bip_q <= bipolar;
      acc <= '0;
      idx <= '0;
    end else if (state == RUN) begin
      acc <= acc + cnt;
      idx <= idx + LOG_LEN'(LANES);
    end
endmodule
